// File: rtl/core_seq_pkg.sv
// Shared types and helpers for the systolic core sequencer.
//   - seq_state_e : sequencer FSM states
//   - INST_*      : inst_w encodings driven to the core
//   - CNT_W       : width of the shared dwell counter
//   - nw()        : weight words per kernel position (doubled in 2-bit mode)
package core_seq_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StArst,
    StAset,
    StWload,
    StGap,
    StAfeed,
    StDrain,
    StRdstart,
    StRdwait,
    StRead,
    StDone
  } seq_state_e;

  localparam logic [1:0] INST_IDLE  = 2'b00;
  localparam logic [1:0] INST_WLOAD = 2'b01;
  localparam logic [1:0] INST_AFEED = 2'b10;

  localparam int unsigned CNT_W = 16;

  function automatic int unsigned nw(input logic mode, input int unsigned mac_col);
    return mode ? 2 * mac_col : mac_col;
  endfunction

endpackage

// File: rtl/core_seq_ctrl_dwell_cnt.sv
// Loadable down-counter shared by every sequencer state.
// Ports:
//   clk, reset : clock, async active-high reset
//   load       : load load_val this cycle (state entry)
//   load_val   : dwell length minus one
//   zero       : counter has reached 0 (state dwell complete)
module seq_dwell_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/core_seq_ctrl.sv
// Hardware sequencer for the systolic core: runs the kij loop (array reset, weight load,
// activation feed, PSUM drain) for every kernel position, then the readout phase.
// Ports:
//   clk, reset            : clock, async active-high reset
//   start, abort          : run request (IDLE only) / cancel in any state
//   act_2b_mode, is_os    : mode inputs, captured on start (act_2b_q, is_os_q)
//   busy, done            : run in progress / one-cycle end-of-run pulse
//   core_reset, inst_w    : core datapath control
//   CEN_xmem, WEN_xmem,
//   A_xmem                : X_MEM read port control (WEN held high)
//   kij                   : current kernel index
//   readout_start/valid   : readout phase handshake to the core
//   perf_cycles           : run cycle count
// Configuration macro: SEQ_PERF_CNT_EN builds the perf counter; otherwise perf_cycles is 0.
module core_seq_ctrl
  import core_seq_pkg::*;
#(
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned MAC_COL   = 8,
  parameter int unsigned LEN_KIJ   = 9,
  parameter int unsigned LEN_NIJ   = 36,
  parameter int unsigned LEN_ONIJ  = 16,
  parameter int unsigned RST_CYC   = 10,
  parameter int unsigned DRAIN_CYC = 30,
  parameter int unsigned W_BASE    = 'h400
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              act_2b_mode,
  input  logic              is_os,
  output logic              busy,
  output logic              done,
  output logic              core_reset,
  output logic [1:0]        inst_w,
  output logic              CEN_xmem,
  output logic              WEN_xmem,
  output logic [ADDR_W-1:0] A_xmem,
  output logic [3:0]        kij,
  output logic              is_os_q,
  output logic              act_2b_q,
  output logic              readout_start,
  output logic              readout_valid,
  output logic [31:0]       perf_cycles
);

  if (W_BASE + LEN_KIJ * 2 * MAC_COL > (1 << ADDR_W)) begin : g_bad_addr_cfg
    $fatal(1, "core_seq_ctrl: weight region exceeds X_MEM address space");
  end
  if (LEN_KIJ < 1 || LEN_KIJ > 16) begin : g_bad_kij_cfg
    $fatal(1, "core_seq_ctrl: LEN_KIJ must be 1..16");
  end

  localparam logic [CNT_W-1:0] RST_LD   = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] NIJ_LD   = CNT_W'(LEN_NIJ - 1);
  localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] ONIJ_LD  = CNT_W'(LEN_ONIJ - 1);
  localparam logic [3:0]       KIJ_LAST = 4'(LEN_KIJ - 1);

  seq_state_e        state_q, state_d;
  logic [3:0]        kij_d;
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_zero;
  logic              accept;
  logic [CNT_W-1:0]  nw_ld;
  logic [ADDR_W-1:0] wl_base;
  logic [1:0]        inst_d;

  assign nw_ld   = CNT_W'(nw(act_2b_q, MAC_COL) - 1);
  assign wl_base = ADDR_W'(W_BASE) + ADDR_W'(kij) * ADDR_W'(nw(act_2b_q, MAC_COL));
  assign accept  = (state_q == StIdle) && (state_d == StArst);

  seq_dwell_cnt #(
    .W (CNT_W)
  ) u_dwell (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  // Next state: every transition reloads the shared counter with the new state's dwell - 1.
  always_comb begin
    state_d  = state_q;
    kij_d    = kij;
    cnt_load = 1'b0;
    cnt_val  = '0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StArst;
          kij_d    = '0;
          cnt_load = 1'b1;
          cnt_val  = RST_LD;
        end
      end
      StArst: if (cnt_zero) begin
        state_d  = StAset;
        cnt_load = 1'b1;
      end
      StAset: if (cnt_zero) begin
        state_d  = StWload;
        cnt_load = 1'b1;
        cnt_val  = nw_ld;
      end
      StWload: if (cnt_zero) begin
        state_d  = StGap;
        cnt_load = 1'b1;
      end
      StGap: if (cnt_zero) begin
        state_d  = StAfeed;
        cnt_load = 1'b1;
        cnt_val  = NIJ_LD;
      end
      StAfeed: if (cnt_zero) begin
        state_d  = StDrain;
        cnt_load = 1'b1;
        cnt_val  = DRAIN_LD;
      end
      StDrain: if (cnt_zero) begin
        cnt_load = 1'b1;
        if (kij < KIJ_LAST) begin
          state_d = StArst;
          kij_d   = kij + 4'd1;
          cnt_val = RST_LD;
        end else begin
          state_d = StRdstart;
        end
      end
      StRdstart: if (cnt_zero) begin
        state_d  = StRdwait;
        cnt_load = 1'b1;
      end
      StRdwait: if (cnt_zero) begin
        state_d  = StRead;
        cnt_load = 1'b1;
        cnt_val  = ONIJ_LD;
      end
      StRead: if (cnt_zero) begin
        state_d  = StDone;
        cnt_load = 1'b1;
      end
      StDone: begin
        state_d = StIdle;
        kij_d   = '0;
      end
      default: begin
        state_d = StIdle;
        kij_d   = '0;
      end
    endcase
    // Abort overrides everything, including a start seen in the same IDLE cycle.
    if (abort) begin
      state_d  = StIdle;
      kij_d    = '0;
      cnt_load = 1'b0;
    end
  end

  always_comb begin
    inst_d = INST_IDLE;
    if (state_d == StWload) inst_d = INST_WLOAD;
    if (state_d == StAfeed) inst_d = INST_AFEED;
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      kij           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      core_reset    <= 1'b0;
      inst_w        <= INST_IDLE;
      CEN_xmem      <= 1'b1;
      A_xmem        <= '0;
      readout_start <= 1'b0;
      readout_valid <= 1'b0;
      is_os_q       <= 1'b0;
      act_2b_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      kij           <= kij_d;
      busy          <= (state_d != StIdle);
      done          <= (state_d == StDone);
      core_reset    <= (state_d == StArst);
      inst_w        <= inst_d;
      CEN_xmem      <= !((state_d == StWload) || (state_d == StAfeed));
      readout_start <= (state_d == StRdstart);
      readout_valid <= (state_d == StRead);
      if (state_d == StWload) begin
        A_xmem <= (state_q == StWload) ? A_xmem + 1'b1 : wl_base;
      end else if (state_d == StAfeed) begin
        A_xmem <= (state_q == StAfeed) ? A_xmem + 1'b1 : '0;
      end else begin
        A_xmem <= '0;
      end
      if (accept) begin
        is_os_q  <= is_os;
        act_2b_q <= act_2b_mode;
      end else if (state_d == StIdle) begin
        is_os_q  <= 1'b0;
        act_2b_q <= 1'b0;
      end
    end
  end

  assign WEN_xmem = 1'b1;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] perf_q;

  // Loading 1 on acceptance counts cycle 0; abort leaves the value frozen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_q <= '0;
    end else if (accept) begin
      perf_q <= 32'd1;
    end else if ((state_d != StIdle) && (perf_q != '1)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_core_seq_ctrl.sv
module tb_core_seq_ctrl;

  localparam int ADDR_W    = 11;
  localparam int MAC_COL   = 8;
  localparam int LEN_KIJ   = 9;
  localparam int LEN_NIJ   = 36;
  localparam int LEN_ONIJ  = 16;
  localparam int RST_CYC   = 10;
  localparam int DRAIN_CYC = 30;
  localparam int W_BASE    = 'h400;

  logic clk, reset, start, abort, act_2b_mode, is_os;
  logic busy, done, core_reset, CEN_xmem, WEN_xmem, is_os_q, act_2b_q;
  logic readout_start, readout_valid;
  logic [1:0] inst_w;
  logic [ADDR_W-1:0] A_xmem;
  logic [3:0] kij;
  logic [31:0] perf_cycles;

  core_seq_ctrl #(
    .ADDR_W(ADDR_W), .MAC_COL(MAC_COL), .LEN_KIJ(LEN_KIJ), .LEN_NIJ(LEN_NIJ),
    .LEN_ONIJ(LEN_ONIJ), .RST_CYC(RST_CYC), .DRAIN_CYC(DRAIN_CYC), .W_BASE(W_BASE)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .act_2b_mode(act_2b_mode),
    .is_os(is_os), .busy(busy), .done(done), .core_reset(core_reset), .inst_w(inst_w),
    .CEN_xmem(CEN_xmem), .WEN_xmem(WEN_xmem), .A_xmem(A_xmem), .kij(kij),
    .is_os_q(is_os_q), .act_2b_q(act_2b_q), .readout_start(readout_start),
    .readout_valid(readout_valid), .perf_cycles(perf_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int nw_of(input bit mode);
    return mode ? 2 * MAC_COL : MAC_COL;
  endfunction
  function automatic int per_of(input bit mode);
    return RST_CYC + nw_of(mode) + LEN_NIJ + DRAIN_CYC + 2;
  endfunction
  function automatic int last_of(input bit mode);
    return per_of(mode) * LEN_KIJ + 2 + LEN_ONIJ;
  endfunction

  // {busy,done,core_reset,inst_w,cen,wen,addr,kij,is_os_q,act_2b_q,rs,rv} = 26 bits
  function automatic logic [25:0] exp_vec(input bit run, input int c, input bit mode,
                                          input bit os);
    logic b, d, cr, cen, rs, rv;
    logic [1:0] iw;
    logic [10:0] a;
    logic [3:0] k;
    int per, kph, t, r, nwv;
    b = 0; d = 0; cr = 0; cen = 1; rs = 0; rv = 0; iw = 2'b00; a = '0; k = '0;
    nwv = nw_of(mode);
    per = per_of(mode);
    kph = per * LEN_KIJ;
    if (run) begin
      b = 1;
      if (c < kph) begin
        k = 4'(c / per);
        t = c % per;
        if (t < RST_CYC) cr = 1;
        else if (t >= RST_CYC + 1 && t < RST_CYC + 1 + nwv) begin
          iw = 2'b01; cen = 0; a = 11'(W_BASE + (c / per) * nwv + t - RST_CYC - 1);
        end else if (t >= RST_CYC + nwv + 2 && t < RST_CYC + nwv + 2 + LEN_NIJ) begin
          iw = 2'b10; cen = 0; a = 11'(t - (RST_CYC + nwv + 2));
        end
      end else begin
        r = c - kph;
        k = 4'(LEN_KIJ - 1);
        rs = (r == 0);
        rv = (r >= 2 && r < 2 + LEN_ONIJ);
        d = (r == 2 + LEN_ONIJ);
      end
    end
    return {b, d, cr, iw, cen, 1'b1, a, k, run ? os : 1'b0, run ? mode : 1'b0, rs, rv};
  endfunction

  bit m_run, m_mode, m_os;
  int m_c;
  logic [31:0] m_perf;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_run <= 0; m_c <= 0; m_mode <= 0; m_os <= 0; m_perf <= 0;
    end else if (abort) begin
      m_run <= 0;
    end else if (!m_run) begin
      if (start) begin
        m_run <= 1; m_c <= 0; m_mode <= act_2b_mode; m_os <= is_os; m_perf <= 1;
      end
    end else if (m_c == last_of(m_mode)) begin
      m_run <= 0;
    end else begin
      m_c <= m_c + 1;
      if (m_perf != 32'hFFFF_FFFF) m_perf <= m_perf + 1;
    end
  end

  // ---------------- compare process + event log ----------------
  logic [10:0] a_log[0:1023];
  logic [1:0]  i_log[0:1023];
  int rs_c, done_c, done_n, busy_n;
  logic [3:0] kij_hist[$];

  task automatic clear_log();
    rs_c = -1; done_c = -1; done_n = 0; busy_n = 0;
    kij_hist.delete();
    for (int i = 0; i < 1024; i++) begin a_log[i] = '0; i_log[i] = '0; end
  endtask

  always @(negedge clk) begin
    logic [25:0] e, g;
    e = exp_vec(m_run, m_c, m_mode, m_os);
    g = {busy, done, core_reset, inst_w, CEN_xmem, WEN_xmem, A_xmem, kij, is_os_q, act_2b_q,
         readout_start, readout_valid};
    if (m_run && e[20]) begin
      e[18:8] = '0;  // address is don't-care while X_MEM is disabled mid-run
      g[18:8] = '0;
    end
    chk("outputs{busy,done,crst,inst,cen,wen,A,kij,os,2b,rs,rv}", 32'(g), 32'(e));
`ifdef SEQ_PERF_CNT_EN
    chk("perf_cycles", perf_cycles, m_perf);
`else
    chk("perf_cycles", perf_cycles, 32'd0);
`endif
    if (m_run && m_c < 1024) begin a_log[m_c] = A_xmem; i_log[m_c] = inst_w; end
    if (readout_start && rs_c < 0) rs_c = m_c;
    if (done) begin done_n++; done_c = m_c; end
    if (busy) busy_n++;
    if (busy && (kij_hist.size() == 0 || kij_hist[$] != kij)) kij_hist.push_back(kij);
  end

  // ---------------- stimulus ----------------
  task automatic wait_c(input int n);
    int k = 0;
    while (!(m_run && m_c == n) && k < 5000) begin @(negedge clk); k++; end
    if (k >= 5000) chk("wait_cycle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_end();
    int k = 0;
    while (m_run && k < 5000) begin @(negedge clk); k++; end
    if (k >= 5000) chk("wait_end_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  task automatic pulse_start(input bit mode, input bit os);
    @(posedge clk); #2;
    start = 1; act_2b_mode = mode; is_os = os;
    @(posedge clk); #2;
    start = 0; act_2b_mode = ~mode; is_os = ~os;
  endtask

  initial begin
    reset = 1; start = 0; abort = 0; act_2b_mode = 0; is_os = 0;
    clear_log();
    repeat (3) @(posedge clk);
    #2 reset = 0;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_cen", 32'(CEN_xmem), 32'd1);
    chk("reset_addr", 32'(A_xmem), 32'd0);

    // Run 1: 4-bit full run
    clear_log();
    pulse_start(1'b0, 1'b1);
    wait_end();
    chk("run1_readout_start_cycle", rs_c, 32'd774);
    chk("run1_done_cycle", done_c, 32'd792);
    chk("run1_done_pulses", done_n, 32'd1);
    chk("run1_busy_cycles", busy_n, 32'd793);
    chk("run1_wload_k3_first", 32'(a_log[3*86+11]), 32'h418);
    chk("run1_wload_k3_last", 32'(a_log[3*86+18]), 32'h41F);
    chk("run1_wload_k3_inst", 32'(i_log[3*86+18]), 32'd1);
`ifdef SEQ_PERF_CNT_EN
    chk("run1_perf_final", perf_cycles, 32'd793);
`else
    chk("run1_perf_zero", perf_cycles, 32'd0);
`endif

    // Run 2: 2-bit, mode toggled mid-run, start held high while busy
    clear_log();
    @(posedge clk); #2;
    start = 1; act_2b_mode = 1; is_os = 0;
    wait_c(100); act_2b_mode = 0;
    wait_c(400); act_2b_mode = 1;
    wait_c(500); act_2b_mode = 0;
    wait_c(864); start = 0;
    wait_end();
    chk("run2_done_cycle", done_c, 32'd864);
    chk("run2_done_pulses", done_n, 32'd1);
    chk("run2_wload_k3_first", 32'(a_log[3*94+11]), 32'h430);
    chk("run2_wload_k3_last", 32'(a_log[3*94+26]), 32'h43F);
    chk("run2_kij_count", kij_hist.size(), 32'd9);
    for (int i = 0; i < kij_hist.size() && i < 9; i++)
      chk("run2_kij_order", 32'(kij_hist[i]), i);

    // Abort during AFEED of kij=5, then a clean full run
    clear_log();
    pulse_start(1'b0, 1'b0);
    wait_c(5*86+30);
    abort = 1;
    @(posedge clk); #2 abort = 0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_inst", 32'(inst_w), 32'd0);
    chk("abort_cen", 32'(CEN_xmem), 32'd1);
    chk("abort_kij", 32'(kij), 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_n, 32'd0);
    clear_log();
    pulse_start(1'b0, 1'b0);
    wait_end();
    chk("post_abort_busy_cycles", busy_n, 32'd793);
    chk("post_abort_done_cycle", done_c, 32'd792);

    // abort and start in the same IDLE cycle
    @(posedge clk); #2 start = 1; abort = 1;
    @(posedge clk); #2 start = 0; abort = 0;
    @(negedge clk);
    chk("abort_start_same_cycle_busy", 32'(busy), 32'd0);

    // Async reset during WLOAD of kij=0
    pulse_start(1'b1, 1'b1);
    wait_c(14);
    @(posedge clk); #3 reset = 1;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_inst", 32'(inst_w), 32'd0);
    chk("async_rst_cen", 32'(CEN_xmem), 32'd1);
    chk("async_rst_addr", 32'(A_xmem), 32'd0);
    chk("async_rst_2b", 32'(act_2b_q), 32'd0);
    chk("async_rst_perf", perf_cycles, 32'd0);
    @(posedge clk); #2 reset = 0;

    // Randomized phase
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #2;
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 499) == 0);
      act_2b_mode = 1'($urandom);
      is_os = 1'($urandom);
    end
    start = 0; abort = 0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
